// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg : shared types and constants for the ALU divider   | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_N = 32;
  localparam int DIV_CNT_W = $clog2(DIV_N);
  localparam logic [DIV_N-1:0] DIV_BY_ZERO_QUOTIENT = '1;

endpackage

`default_nettype wire

// File: rtl/subtractor.sv
// ---------------------------------------------------------------------------
// subtractor : combinational ripple-borrow W-bit a - b        | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module subtractor #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0] w_bor;

  assign w_bor[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign diff[i]    = a[i] ^ b[i] ^ w_bor[i];
    assign w_bor[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_bor[i]);
  end

  assign borrow = w_bor[W];

endmodule

`default_nettype wire

// File: rtl/alu_divider.sv
// ---------------------------------------------------------------------------
// alu_divider : multi-cycle unsigned restoring divider, 1 bit/clk | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_divider
  import alu_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         result_valid,
  input  logic         result_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic         busy
);

  localparam int CNT_W = $clog2(N);
  localparam logic [N-1:0] C_DBZ_Q = '1;

  div_state_t       r_state, w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     r_dvs;
  logic [N-1:0]     r_q;
  logic [N:0]       r_rem;
  logic [N-1:0]     r_quot;
  logic [N-1:0]     r_remd;
  logic             r_dbz;
  logic             r_valid;

  logic [N:0]       w_t;
  logic [N:0]       w_diff;
  logic             w_borrow;
  logic [N:0]       w_rem_next;
  logic [N-1:0]     w_q_next;
  logic             w_accept;
  logic             w_unused;

  assign w_t        = {r_rem[N-1:0], r_q[N-1]};
  assign w_rem_next = w_borrow ? w_t : w_diff;
  assign w_q_next   = {r_q[N-2:0], ~w_borrow};
  assign w_accept   = start_valid && (r_state == IDLE);
  // The remainder MSB is structurally zero once an iteration is stored.
  assign w_unused   = r_rem[N];

  subtractor #(.W(N + 1)) u_sub (
    .a      (w_t),
    .b      ({1'b0, r_dvs}),
    .diff   (w_diff),
    .borrow (w_borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = (divisor == '0) ? DONE : RUN;
      RUN:     if (r_cnt == '0) w_next_state = DONE;
      DONE:    if (r_valid && result_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    start_ready = (r_state == IDLE);
    busy        = (r_state != IDLE);
  end

  // Results land in dedicated registers so partial shifts never reach the ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_dvs   <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_quot  <= '0;
      r_remd  <= '0;
      r_dbz   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_valid <= 1'b0;
          if (w_accept) begin
            r_dvs <= divisor;
            r_q   <= dividend;
            r_rem <= '0;
            r_cnt <= CNT_W'(N - 1);
            r_dbz <= (divisor == '0);
            if (divisor == '0) begin
              r_quot <= C_DBZ_Q;
              r_remd <= dividend;
            end
          end
        end
        RUN: begin
          r_q   <= w_q_next;
          r_rem <= w_rem_next;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_quot <= w_q_next;
            r_remd <= w_rem_next[N-1:0];
          end
        end
        DONE: begin
          // Valid rises one edge after DONE is entered and drops when taken.
          if (!r_valid)          r_valid <= 1'b1;
          else if (result_ready) r_valid <= 1'b0;
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end

  assign quotient     = r_quot;
  assign remainder    = r_remd;
  assign div_by_zero  = r_dbz;
  assign result_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_alu_divider.sv
// ---------------------------------------------------------------------------
// tb_alu_divider : directed self-checking bench for alu_divider  | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  alu_divider #(.N(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .dividend     (dividend),
    .divisor      (divisor),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_by_zero  (div_by_zero),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [31:0] dvd, input logic [31:0] dvs);
    @(negedge clk);
    start_valid = 1'b1;
    dividend    = dvd;
    divisor     = dvs;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    dividend    = 32'hDEAD_BEEF;
    divisor     = 32'h0;
  endtask

  task automatic wait_result();
    lat = 0;
    while (!result_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take_result(input string tag);
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(result_valid), 32'd0);
    check({tag, "_idle"}, 32'(start_ready), 32'd1);
  endtask

  task automatic run_div(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                         input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                         input int elat);
    accept(dvd, dvs);
    wait_result();
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
    take_result(tag);
  endtask

  initial begin
    #12;
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    run_div("d5_0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);

    // Sticky zero-divide flag must clear on the next accept.
    accept(32'hFFFF_FFFF, 32'd1);
    check("dbz_clear", 32'(div_by_zero), 32'd0);
    check("run_busy", 32'(busy), 32'd1);
    check("run_hold_q", quotient, 32'hFFFF_FFFF);
    wait_result();
    check("max_1_lat", 32'(lat), 32'd33);
    check("max_1_q", quotient, 32'hFFFF_FFFF);
    check("max_1_r", remainder, 32'd0);
    take_result("max_1");

    run_div("d3_10", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 33);
    run_div("d8m_max", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33);

    // Backpressure with ignored start pulses.
    accept(32'd100, 32'd7);
    wait_result();
    check("bp_lat", 32'(lat), 32'd33);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_valid = (i % 2 == 0);
      dividend    = 32'd999;
      divisor     = 32'd0;
      @(posedge clk);
      #1;
      check("bp_valid", 32'(result_valid), 32'd1);
      check("bp_start_ready", 32'(start_ready), 32'd0);
      check("bp_q", quotient, 32'd14);
      check("bp_r", remainder, 32'd2);
      check("bp_dbz", 32'(div_by_zero), 32'd0);
    end
    start_valid = 1'b0;
    take_result("bp");
    check("bp_no_accept", 32'(busy), 32'd0);

    // Reset in the middle of a run.
    accept(32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(result_valid), 32'd0);
    check("mid_rst_ready", 32'(start_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_q", quotient, 32'd0);
    check("mid_rst_r", remainder, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("mid_rst_hold_valid", 32'(result_valid), 32'd0);
    end
    #1;
    rst_n = 1'b1;
    run_div("d20_4", 32'd20, 32'd4, 32'd5, 32'd0, 1'b0, 33);

    // Back-to-back: next accept on the edge after the result is taken.
    run_div("b2b_a", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33);
    run_div("b2b_b", 32'd0, 32'd9, 32'd0, 32'd0, 1'b0, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
